mem_port_arbiter: RTL and testbench

- Shares the single unified memory read/write port between the instruction-fetch requester and the load/store/call/return data requester.
- Serialises accesses through a small FSM, holds each access for a fixed memory latency, and returns read data with a one-cycle valid pulse.
- Sits between the fetch/memory-handler logic and the byte-addressed memory array inside tinker_core.
- Data side has priority; a starvation limit guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter
// Shares one memory port between instruction fetch and data accesses.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN (alternating winners on conflict)
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int                ADDR_W       = 64,
    parameter int                DATA_W       = 64,
    parameter int                MEM_LATENCY  = 1,
    parameter int                STARVE_LIMIT = 4,
    parameter logic [ADDR_W-1:0] IDLE_ADDR    = 'h2000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              first_q, first_d;
    logic              owner_q, owner_d;   // 1 = data side owns the access
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic fetch_wins;
    logic grant_ok;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 1 = data won the previous grant, so fetch takes the next conflict
    logic last_owner_q, last_owner_d;

    always_comb begin
        fetch_wins = if_req && (!d_req || last_owner_q);
    end

    always_comb begin
        last_owner_d = last_owner_q;
        if (if_gnt) begin
            last_owner_d = 1'b0;
        end else if (d_gnt) begin
            last_owner_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner_q <= 1'b0;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`else
    logic [3:0] starve_q, starve_d;

    always_comb begin
        fetch_wins = if_req && (!d_req || (starve_q == 4'(STARVE_LIMIT)));
    end

    always_comb begin
        starve_d = starve_q;
        if (if_gnt) begin
            starve_d = 4'd0;
        end else if (d_gnt && if_req && (starve_q != 4'(STARVE_LIMIT))) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    // Grants are combinational, so reset must mask them directly
    always_comb begin
        grant_ok = (state_q == ST_IDLE) && !reset;
        if_gnt   = grant_ok && fetch_wins;
        d_gnt    = grant_ok && d_req && !fetch_wins;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        first_d    = first_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (if_gnt || d_gnt) begin
                    state_d = ST_BUSY;
                    cnt_d   = 4'(MEM_LATENCY);
                    first_d = 1'b1;
                    owner_d = d_gnt;
                    we_d    = d_gnt && d_we;
                    addr_d  = d_gnt ? d_addr : if_addr;
                    wdata_d = (d_gnt && d_we) ? d_wdata : '0;
                end
            end
            ST_BUSY: begin
                first_d = 1'b0;
                cnt_d   = cnt_q - 4'd1;
                // <= 1 also guards an out-of-range latency of 0
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_RESP;
                    if (owner_q) begin
                        d_rdata_d = we_q ? '0 : mem_rdata;
                    end else begin
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            first_q    <= 1'b0;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        mem_addr  = (state_q == ST_IDLE) ? IDLE_ADDR : addr_q;
        mem_we    = (state_q == ST_BUSY) && first_q && we_q;
        mem_wdata = (state_q == ST_BUSY) ? wdata_q : '0;
        if_rvalid = (state_q == ST_RESP) && !owner_q;
        d_rvalid  = (state_q == ST_RESP) && owner_q;
        if_rdata  = if_rdata_q;
        d_rdata   = d_rdata_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter
// Directed self-checking bench for mem_port_arbiter (latency 1 and latency 3).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;

    logic        if_req, if_gnt, if_rvalid;
    logic [63:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [63:0] d_addr, d_wdata, d_rdata;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, busy;

    logic        if3_req, if3_gnt, if3_rvalid;
    logic [63:0] if3_addr, if3_rdata;
    logic        d3_req, d3_we, d3_gnt, d3_rvalid;
    logic [63:0] d3_addr, d3_wdata, d3_rdata;
    logic [63:0] mem3_addr, mem3_wdata, mem3_rdata;
    logic        mem3_we, busy3;

    logic [63:0] mem [0:15];

    int checks;
    int fails;

    mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
        .clk(clk), .reset(reset),
        .if_req(if3_req), .if_addr(if3_addr), .if_gnt(if3_gnt),
        .if_rvalid(if3_rvalid), .if_rdata(if3_rdata),
        .d_req(d3_req), .d_we(d3_we), .d_addr(d3_addr), .d_wdata(d3_wdata),
        .d_gnt(d3_gnt), .d_rvalid(d3_rvalid), .d_rdata(d3_rdata),
        .mem_addr(mem3_addr), .mem_we(mem3_we), .mem_wdata(mem3_wdata),
        .mem_rdata(mem3_rdata), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-per-4KB memory model: index by address bits [15:12]
    assign mem_rdata  = mem[mem_addr[15:12]];
    assign mem3_rdata = mem3_addr ^ 64'hFFFF_0000;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[15:12]] <= mem_wdata;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        if_req = 1'b1;
        d_req  = 1'b1;
        step();
        step();
        @(negedge clk);
        checks++;
        if ({if_gnt, d_gnt} !== 2'b00) begin
            fails++; $display("FAIL reset_gnt: got %b expected 00", {if_gnt, d_gnt});
        end
        checks++;
        if ({if_rvalid, d_rvalid, mem_we, busy} !== 4'b0000) begin
            fails++; $display("FAIL reset_ctrl: got %b expected 0000", {if_rvalid, d_rvalid, mem_we, busy});
        end
        checks++;
        if (mem_addr !== 64'h2000) begin
            fails++; $display("FAIL reset_mem_addr: got %h expected %h", mem_addr, 64'h2000);
        end
        checks++;
        if ({if_rdata, d_rdata, mem_wdata} !== 192'd0) begin
            fails++; $display("FAIL reset_data: got %h %h %h expected zeros", if_rdata, d_rdata, mem_wdata);
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_fetch_read();
        logic [4:0] g, b, rv;
        if_req  = 1'b1;
        if_addr = 64'h2000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            g[c]  = if_gnt;
            b[c]  = busy;
            rv[c] = if_rvalid;
            if (c == 2) begin
                checks++;
                if (if_rdata !== 64'h0A2C4000) begin
                    fails++; $display("FAIL fetch_rdata: got %h expected %h", if_rdata, 64'h0A2C4000);
                end
            end
            step();
            if (c == 0) if_req = 1'b0;
        end
        checks++;
        if (g !== 5'b00001) begin
            fails++; $display("FAIL fetch_gnt_timing: got %b expected %b", g, 5'b00001);
        end
        checks++;
        if (b !== 5'b00110) begin
            fails++; $display("FAIL fetch_busy_timing: got %b expected %b", b, 5'b00110);
        end
        checks++;
        if (rv !== 5'b00100) begin
            fails++; $display("FAIL fetch_rvalid_timing: got %b expected %b", rv, 5'b00100);
        end
    endtask

    task automatic test_write_read();
        logic [4:0] we_v, rv;
        logic [4:0] addr_ok;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 64'h3000;
        d_wdata = 64'h1122334455667788;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            we_v[c]    = mem_we;
            addr_ok[c] = (mem_addr == 64'h3000) && (mem_wdata == 64'h1122334455667788);
            rv[c]      = d_rvalid;
            if (c == 2) begin
                checks++;
                if (d_rdata !== 64'd0) begin
                    fails++; $display("FAIL write_ack_rdata: got %h expected 0", d_rdata);
                end
            end
            step();
            if (c == 0) d_req = 1'b0;
        end
        checks++;
        if (we_v !== 5'b00010 || addr_ok[1] !== 1'b1) begin
            fails++; $display("FAIL write_strobe: got we=%b addr_ok=%b expected we=00010 addr_ok[1]=1", we_v, addr_ok);
        end
        checks++;
        if (rv !== 5'b00100) begin
            fails++; $display("FAIL write_ack_timing: got %b expected %b", rv, 5'b00100);
        end

        d_req = 1'b1;
        d_we  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            we_v[c] = mem_we;
            rv[c]   = d_rvalid;
            if (c == 2) begin
                checks++;
                if (d_rdata !== 64'h1122334455667788) begin
                    fails++; $display("FAIL read_back: got %h expected %h", d_rdata, 64'h1122334455667788);
                end
            end
            step();
            if (c == 0) d_req = 1'b0;
        end
        checks++;
        if (rv !== 5'b00100 || we_v !== 5'b00000) begin
            fails++; $display("FAIL read_pulse: got rv=%b we=%b expected rv=00100 we=00000", rv, we_v);
        end
    endtask

    task automatic test_starvation();
        logic [9:0] order;
        logic [9:0] exp_order;
        int ngr, first_c, last_c;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_order = 10'b1010101010;
`else
        exp_order = 10'b1111011110;
`endif
        reset = 1'b1;
        step();
        reset   = 1'b0;
        order   = '0;
        ngr     = 0;
        first_c = 0;
        last_c  = 0;
        if_req  = 1'b1;
        if_addr = 64'h1000;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 64'h4000;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (d_gnt || if_gnt) begin
                order = {order[8:0], d_gnt};
                if (ngr == 0) first_c = c;
                last_c = c;
                ngr++;
            end
            step();
            if (ngr == 10) break;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        checks++;
        if (ngr != 10) begin
            fails++; $display("FAIL starve_timeout: got %0d grants expected 10", ngr);
        end
        checks++;
        if (order !== exp_order) begin
            fails++; $display("FAIL starve_order: got %b expected %b (1=data)", order, exp_order);
        end
        checks++;
        if (last_c - first_c != 27) begin
            fails++; $display("FAIL grant_spacing: got %0d expected 27", last_c - first_c);
        end
        for (int c = 0; c < 4; c++) step();
        checks++;
        if (if_rdata !== 64'hA5A5_0000_0000_0001 || d_rdata !== 64'hA5A5_0000_0000_0004) begin
            fails++; $display("FAIL contested_rdata: got %h %h expected %h %h", if_rdata, d_rdata,
                              64'hA5A5_0000_0000_0001, 64'hA5A5_0000_0000_0004);
        end
    endtask

    task automatic test_latency3();
        logic [6:0] dg, ig, dr;
        d3_req   = 1'b1;
        d3_we    = 1'b0;
        d3_addr  = 64'h5000;
        if3_req  = 1'b1;
        if3_addr = 64'h6000;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            dg[c] = d3_gnt;
            ig[c] = if3_gnt;
            dr[c] = d3_rvalid;
            if (c == 4) begin
                checks++;
                if (d3_rdata !== 64'h0000_0000_FFFF_5000) begin
                    fails++; $display("FAIL lat3_rdata: got %h expected %h", d3_rdata, 64'h0000_0000_FFFF_5000);
                end
            end
            step();
            if (c == 0) d3_req = 1'b0;
            if (c == 5) if3_req = 1'b0;
        end
        checks++;
        if (dg !== 7'b0000001) begin
            fails++; $display("FAIL lat3_d_gnt: got %b expected %b", dg, 7'b0000001);
        end
        checks++;
        if (ig !== 7'b0100000) begin
            fails++; $display("FAIL lat3_if_gnt: got %b expected %b", ig, 7'b0100000);
        end
        checks++;
        if (dr !== 7'b0010000) begin
            fails++; $display("FAIL lat3_d_rvalid: got %b expected %b", dr, 7'b0010000);
        end
        for (int c = 0; c < 6; c++) step();
    endtask

    task automatic test_reset_mid_access();
        int d_rv_cnt, if_rv_cnt;
        d_rv_cnt  = 0;
        if_rv_cnt = 0;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 64'h4000;
        if_req  = 1'b1;
        if_addr = 64'h1000;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1) begin
            fails++; $display("FAIL rst_mid_setup_gnt: got %b expected 1", d_gnt);
        end
        step();
        d_req = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, d_rvalid, if_rvalid, if_gnt, d_gnt, mem_we} !== 6'b000000 ||
            mem_addr !== 64'h2000 || d_rdata !== 64'd0 || if_rdata !== 64'd0) begin
            fails++; $display("FAIL rst_mid_outputs: got ctrl=%b addr=%h d_rdata=%h if_rdata=%h expected 000000 2000 0 0",
                              {busy, d_rvalid, if_rvalid, if_gnt, d_gnt, mem_we}, mem_addr, d_rdata, if_rdata);
        end
        step();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (if_gnt !== 1'b1) begin
            fails++; $display("FAIL rst_mid_first_gnt: got %b expected 1", if_gnt);
        end
        step();
        if_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (d_rvalid) d_rv_cnt++;
            if (if_rvalid) if_rv_cnt++;
            step();
        end
        checks++;
        if (d_rv_cnt != 0 || if_rv_cnt != 1) begin
            fails++; $display("FAIL rst_mid_rvalid: got d=%0d if=%0d expected d=0 if=1", d_rv_cnt, if_rv_cnt);
        end
        checks++;
        if (if_rdata !== 64'hA5A5_0000_0000_0001) begin
            fails++; $display("FAIL rst_mid_fetch_data: got %h expected %h", if_rdata, 64'hA5A5_0000_0000_0001);
        end
    endtask

    task automatic test_idle();
        int bad;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_addr !== 64'h2000 || mem_we !== 1'b0 || busy !== 1'b0 ||
                if_gnt !== 1'b0 || d_gnt !== 1'b0 || if_rvalid !== 1'b0 || d_rvalid !== 1'b0)
                bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            fails++; $display("FAIL idle_quiet: got %0d bad cycles expected 0", bad);
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        for (int i = 0; i < 16; i++) mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
        mem[2] = 64'h0000_0000_0A2C_4000;
        reset    = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_addr   = '0;
        d_wdata  = '0;
        if3_req  = 1'b0;
        if3_addr = '0;
        d3_req   = 1'b0;
        d3_we    = 1'b0;
        d3_addr  = '0;
        d3_wdata = '0;
        #1;
        test_reset();
        test_fetch_read();
        test_write_read();
        test_starvation();
        test_latency3();
        test_reset_mid_access();
        test_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
